// File: rtl/pulse_encoder.sv
// Pulse-interval encoder: frames each accepted word as a fixed preamble followed by
// short/long gap pulse pairs (one pair per bit, MSB first) and a trailing idle gap.
module pulse_encoder #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned SHORT_GAP = 2,
   parameter int unsigned LONG_GAP  = 6,
   parameter int unsigned FRAME_GAP = 16
) (
   input  logic             CLK_IN,
   input  logic             RST_IN,
   input  logic [WIDTH-1:0] TX_DATA,
   input  logic             TX_VALID,
   output logic             TX_READY,
   output logic             DATA_OUT,
   output logic             BUSY,
   output logic             FRAME_DONE
);

   localparam int unsigned BCW  = $clog2(WIDTH + 1);
   localparam int unsigned MAXG = (LONG_GAP > FRAME_GAP) ? LONG_GAP : FRAME_GAP;
   localparam int unsigned ICW  = $clog2(((MAXG > 5) ? MAXG : 5) + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_PREAMBLE = 3'd1;
   localparam logic [2:0] S_GAP_A    = 3'd2;
   localparam logic [2:0] S_PULSE_A  = 3'd3;
   localparam logic [2:0] S_GAP_B    = 3'd4;
   localparam logic [2:0] S_PULSE_B  = 3'd5;
   localparam logic [2:0] S_TRAIL    = 3'd6;

   localparam logic [ICW-1:0] PRE_LAST   = ICW'(4);
   localparam logic [ICW-1:0] SHORT_LAST = ICW'(SHORT_GAP - 1);
   localparam logic [ICW-1:0] LONG_LAST  = ICW'(LONG_GAP - 1);
   localparam logic [ICW-1:0] TRAIL_LAST = ICW'(FRAME_GAP - 1);
   localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);

   logic [2:0]       r_state;
   logic [ICW-1:0]   r_cnt;
   logic [BCW-1:0]   r_bit;
   logic [WIDTH-1:0] r_shift;
   logic             r_data_out;
   logic             r_busy;
   logic             r_frame_done;

   logic [2:0]       w_state_nxt;
   logic [ICW-1:0]   w_cnt_nxt;
   logic [BCW-1:0]   w_bit_nxt;
   logic [WIDTH-1:0] w_shift_nxt;
   logic             w_dout_nxt;
   logic             w_done_nxt;
   logic [ICW-1:0]   w_gap_a_last;
   logic [ICW-1:0]   w_gap_b_last;

   // A 1 bit puts the long interval first, a 0 bit the short one.
   assign w_gap_a_last = r_shift[WIDTH-1] ? LONG_LAST  : SHORT_LAST;
   assign w_gap_b_last = r_shift[WIDTH-1] ? SHORT_LAST : LONG_LAST;

   assign TX_READY   = (r_state == S_IDLE);
   assign DATA_OUT   = r_data_out;
   assign BUSY       = r_busy;
   assign FRAME_DONE = r_frame_done;

   // Next-state logic; DATA_OUT/FRAME_DONE are computed for the next cycle so they leave a flop.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_dout_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (TX_VALID) begin
               w_state_nxt = S_PREAMBLE;
               w_cnt_nxt   = '0;
               w_bit_nxt   = '0;
               w_shift_nxt = TX_DATA;
               w_dout_nxt  = 1'b1;
            end
         end
         S_PREAMBLE: begin
            if (r_cnt == PRE_LAST) begin
               w_state_nxt = S_GAP_A;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt  = r_cnt + ICW'(1);
               w_dout_nxt = r_cnt[0];
            end
         end
         S_GAP_A: begin
            if (r_cnt == w_gap_a_last) begin
               w_state_nxt = S_PULSE_A;
               w_cnt_nxt   = '0;
               w_dout_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + ICW'(1);
            end
         end
         S_PULSE_A: begin
            w_state_nxt = S_GAP_B;
            w_cnt_nxt   = '0;
         end
         S_GAP_B: begin
            if (r_cnt == w_gap_b_last) begin
               w_state_nxt = S_PULSE_B;
               w_cnt_nxt   = '0;
               w_dout_nxt  = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + ICW'(1);
            end
         end
         S_PULSE_B: begin
            w_cnt_nxt = '0;
            if (r_bit == BIT_LAST) begin
               w_state_nxt = S_TRAIL;
               w_done_nxt  = (FRAME_GAP == 1);
            end else begin
               w_state_nxt = S_GAP_A;
               w_bit_nxt   = r_bit + BCW'(1);
               w_shift_nxt = r_shift << 1;
            end
         end
         S_TRAIL: begin
            if (r_cnt == TRAIL_LAST) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt  = r_cnt + ICW'(1);
               w_done_nxt = ((r_cnt + ICW'(1)) == TRAIL_LAST);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK_IN) begin
      if (RST_IN) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit        <= '0;
         r_shift      <= '0;
         r_data_out   <= 1'b0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bit        <= w_bit_nxt;
         r_shift      <= w_shift_nxt;
         r_data_out   <= w_dout_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_frame_done <= w_done_nxt;
      end
   end

endmodule

// File: tb/tb_pulse_encoder.sv
// Scoreboard bench for pulse_encoder: queued expected words, per-cycle waveform model and a pulse-interval decoder.
module tb_pulse_encoder;

   localparam int W    = 8;
   localparam int SG   = 2;
   localparam int LG   = 6;
   localparam int FG   = 16;
   localparam int B    = SG + LG + 2;
   localparam int FLEN = 5 + W * B + FG;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic         data_out;
   logic         busy;
   logic         frame_done;

   always #5 clk = ~clk;

   pulse_encoder #(.WIDTH(W), .SHORT_GAP(SG), .LONG_GAP(LG), .FRAME_GAP(FG)) dut (
      .CLK_IN     (clk),
      .RST_IN     (rst),
      .TX_DATA    (tx_data),
      .TX_VALID   (tx_valid),
      .TX_READY   (tx_ready),
      .DATA_OUT   (data_out),
      .BUSY       (busy),
      .FRAME_DONE (frame_done)
   );

   int           checks = 0;
   int           errors = 0;
   int           cyc = 0;
   logic [W-1:0] exp_q[$];
   int           pulses[$];
   bit           active = 1'b0;
   bit           mon_en = 1'b0;
   int           off = 0;
   logic [W-1:0] cur_word;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d, offset %0d)", name, act, exp, cyc, off);
      end
   endtask

   // Expected line level at a frame offset, straight from the framing rules.
   function automatic logic model_dout(input logic [W-1:0] w, input int o);
      int k;
      int p;
      int first;
      if (o >= 1 && o <= 5) return logic'(o % 2 == 1);
      if (o >= 6 && o < 6 + W * B) begin
         k     = (o - 6) / B;
         p     = (o - 6) % B;
         first = w[W-1-k] ? LG : SG;
         return logic'(p == first || p == B - 1);
      end
      return 1'b0;
   endfunction

   // Companion decoder: recovers each bit from the idle run preceding its first pulse.
   function automatic logic [W-1:0] decode_pulses();
      logic [W-1:0] w;
      int gap;
      w = '0;
      for (int k = 0; k < W; k++) begin
         gap = pulses[3+2*k] - pulses[2+2*k] - 1;
         w[W-1-k] = (gap == LG);
      end
      return w;
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         if (active) begin
            off = off + 1;
            chk("data_out", 32'(data_out), 32'(model_dout(cur_word, off)));
            chk("frame_done", 32'(frame_done), 32'(off == FLEN));
            chk("busy_in_frame", 32'(busy), 1);
            chk("tx_ready_in_frame", 32'(tx_ready), 0);
            if (data_out === 1'b1) pulses.push_back(off);
            if (off == FLEN) begin
               chk("pulse_count", 32'(pulses.size()), 32'(3 + 2 * W));
               if (pulses.size() == 3 + 2 * W) chk("decoded_word", 32'(decode_pulses()), 32'(cur_word));
               active = 1'b0;
            end
            if (rst) active = 1'b0;
         end else begin
            chk("idle_data_out", 32'(data_out), 0);
            chk("idle_frame_done", 32'(frame_done), 0);
            chk("idle_busy", 32'(busy), 0);
            chk("idle_tx_ready", 32'(tx_ready), 1);
            if (tx_valid && tx_ready && !rst) begin
               chk("accept_expected", 32'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) cur_word = exp_q.pop_front();
               active = 1'b1;
               off    = 0;
               pulses.delete();
            end
         end
      end
   end

   task automatic send(input logic [W-1:0] w, input bit hold, output int acc_cyc);
      exp_q.push_back(w);
      tx_data  = w;
      tx_valid = 1'b1;
      acc_cyc  = -1;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (tx_ready === 1'b1 && !rst) begin
            acc_cyc = cyc;
            break;
         end
      end
      chk("accept_timeout", 32'(acc_cyc >= 0), 1);
      @(posedge clk);
      #1;
      if (!hold) tx_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         if (tx_ready === 1'b1 && !active) begin
            ok = 1'b1;
            break;
         end
      end
      chk("idle_timeout", 32'(ok), 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int a1;
      int a2;
      int g;
      rst      = 1'b1;
      tx_valid = 1'b0;
      tx_data  = '0;
      repeat (3) @(posedge clk);
      #1;
      rst    = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);
      chk("reset_tx_ready", 32'(tx_ready), 1);
      chk("reset_data_out", 32'(data_out), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_frame_done", 32'(frame_done), 0);
      @(posedge clk);
      #1;

      send(8'h00, 1'b0, a1);
      wait_idle();
      send(8'hA5, 1'b0, a1);
      wait_idle();

      // Back-to-back with TX_VALID held: second acceptance right after FRAME_DONE.
      send(8'hFF, 1'b1, a1);
      send(8'h01, 1'b0, a2);
      chk("b2b_spacing", 32'(a2 - a1), 32'(FLEN + 1));
      wait_idle();

      // Word offered mid-frame must be ignored.
      send(8'h5A, 1'b0, a1);
      repeat (39) @(posedge clk);
      #1;
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(posedge clk);
      #1;
      tx_valid = 1'b0;
      wait_idle();

      // Reset at offset 50 aborts the frame.
      send(8'hC3, 1'b0, a1);
      repeat (49) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (30) @(posedge clk);
      #1;

      // Reset and TX_VALID on the same edge: word dropped.
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      tx_valid = 1'b0;
      @(negedge clk);
      chk("collide_busy", 32'(busy), 0);
      chk("collide_tx_ready", 32'(tx_ready), 1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 100; i++) begin
         g = int'($urandom_range(0, 3));
         repeat (g) begin
            @(posedge clk);
            #1;
         end
         send(W'($urandom), 1'b0, a1);
      end
      wait_idle();
      chk("queue_empty", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pulse_encoder.md
PULSE_ENCODER -- requirements
Module: pulse_encoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, payload bits per frame.
REQ-002 SHALL have parameter SHORT_GAP, default 2, idle cycles in the short interval.
REQ-003 SHALL have parameter LONG_GAP, default 6, idle cycles in the long interval.
REQ-004 SHALL have parameter FRAME_GAP, default 16, idle cycles after the last pulse of a frame.
REQ-005 SHALL have port CLK_IN  input  1  single clock; all logic on its rising edge.
REQ-006 SHALL have port RST_IN  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port TX_DATA  input  WIDTH  payload word, sampled on acceptance.
REQ-008 SHALL have port TX_VALID  input  1  payload word present.
REQ-009 SHALL have port TX_READY  output  1  encoder can accept a word.
REQ-010 SHALL have port DATA_OUT  output  1  registered pulse stream to the downstream decoder.
REQ-011 SHALL have port BUSY  output  1  high from acceptance until FRAME_DONE inclusive.
REQ-012 SHALL have port FRAME_DONE  output  1  one-cycle strobe in the last trailing-gap cycle.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, GAP_A, PULSE_A, GAP_B, PULSE_B, TRAIL.
REQ-014 SHALL drive TX_READY high only in IDLE, combinationally from state.
REQ-015 SHALL accept a word at a rising edge where TX_VALID and TX_READY are both high (acceptance edge, offset 0), latching TX_DATA.
REQ-016 SHALL ignore TX_DATA and TX_VALID in every state other than IDLE.
REQ-017 SHALL emit preamble DATA_OUT = 1,0,1,0,1 at offsets 1..5.
REQ-018 SHALL send payload MSB first; bit k (k=0 is MSB) occupies offsets 6+B*k .. 5+B*(k+1), with B = SHORT_GAP+LONG_GAP+2.
REQ-019 SHALL encode bit 0 as SHORT_GAP zeros, one 1, LONG_GAP zeros, one 1.
REQ-020 SHALL encode bit 1 as LONG_GAP zeros, one 1, SHORT_GAP zeros, one 1.
REQ-021 SHALL keep every DATA_OUT pulse exactly one cycle wide; no two pulses adjacent outside the preamble.
REQ-022 SHALL hold DATA_OUT at 0 for FRAME_GAP cycles (TRAIL) after the last payload pulse, assert FRAME_DONE in the final TRAIL cycle, then enter IDLE.
REQ-023 SHALL give total frame length 5 + WIDTH*B + FRAME_GAP cycles, acceptance to FRAME_DONE inclusive (101 at defaults).
REQ-024 SHALL accept back-to-back words: TX_READY high the cycle after FRAME_DONE; the next acceptance may occur on that edge.
REQ-025 SHALL use a bit counter of ceil(log2(WIDTH+1)) bits and an interval counter wide enough for max(LONG_GAP, FRAME_GAP); neither counter wraps mid-frame.
REQ-026 SHALL require SHORT_GAP >= 1, LONG_GAP > SHORT_GAP + 1, FRAME_GAP >= 1; other values are unsupported.
REQ-027 SHALL keep DATA_OUT 0 whenever in IDLE.

Reset
REQ-028 SHALL, on RST_IN high at a rising edge, enter IDLE and set DATA_OUT=0, BUSY=0, FRAME_DONE=0, counters=0, so TX_READY=1 in the following cycle.
REQ-029 SHALL abort any frame in progress on reset with no further pulses and no FRAME_DONE.
REQ-030 SHALL give reset priority over acceptance when RST_IN and TX_VALID are both high on the same edge; the word is dropped.

Verification
REQ-031 SHALL verify: TX_DATA=8'h00 accepted -> DATA_OUT high at offsets 1,3,5,8,15,18,25,...,78,85; FRAME_DONE at 101; TX_READY high at 102.
REQ-032 SHALL verify: TX_DATA=8'hA5 -> bit pulses at offsets 12,15 | 18,25 | 32,35 | 38,45 | 48,55 | 62,65 | 68,75 | 82,85; no other pulses after offset 5.
REQ-033 SHALL verify: TX_VALID held high with 8'hFF then 8'h01 -> second acceptance on the edge after FRAME_DONE; second preamble at offsets 1,3,5 relative to it.
REQ-034 SHALL verify: TX_VALID pulsed with 8'h3C at offset 40 of a frame -> word ignored; current frame unchanged; TX_READY stays 0.
REQ-035 SHALL verify: RST_IN asserted for one cycle at offset 50 -> DATA_OUT 0 from the next cycle; no FRAME_DONE; TX_READY=1 after reset.
REQ-036 SHALL verify: decoded output of a companion pulse decoder (timeout 1000) matches each transmitted word for 100 random words.
